// File: rtl/remote_comm_mb.sv
// remote_comm_mb: multi-byte command sender / response collector over a built-in 8N1 UART.
// Optional build macro REMOTE_COMM_TIMEOUT_EN adds a response inter-byte timeout.
`default_nettype none

module remote_comm_uart_tx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       TX,
  output logic       tx_done
);
  localparam int BW = $clog2(CLKS_PER_BIT + 1);

  logic [9:0]    sh;
  logic [BW-1:0] baud;
  logic [3:0]    bit_idx;
  logic          active;

  assign TX = active ? sh[0] : 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh      <= '1;
      baud    <= '0;
      bit_idx <= '0;
      active  <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (!active) begin
        if (trmt) begin
          sh      <= {1'b1, tx_data, 1'b0};
          active  <= 1'b1;
          baud    <= '0;
          bit_idx <= '0;
        end
      end else if (baud == BW'(CLKS_PER_BIT - 1)) begin
        baud <= '0;
        sh   <= {1'b1, sh[9:1]};
        if (bit_idx == 4'd9) begin
          active  <= 1'b0;
          tx_done <= 1'b1;
        end else begin
          bit_idx <= bit_idx + 4'd1;
        end
      end else begin
        baud <= baud + BW'(1);
      end
    end
  end
endmodule

module remote_comm_uart_rx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  input  logic       clr_rx_rdy,
  output logic [7:0] rx_data,
  output logic       rx_rdy
);
  localparam int BW = $clog2(CLKS_PER_BIT + 1);

  logic          rx_m, rx_s;
  logic [7:0]    sh;
  logic [BW-1:0] baud;
  logic [3:0]    bit_idx;
  logic          active;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m    <= 1'b1;
      rx_s    <= 1'b1;
      sh      <= '0;
      baud    <= '0;
      bit_idx <= '0;
      active  <= 1'b0;
      rx_data <= '0;
      rx_rdy  <= 1'b0;
    end else begin
      rx_m <= RX;
      rx_s <= rx_m;
      if (clr_rx_rdy) rx_rdy <= 1'b0;
      if (!active) begin
        if (!rx_s) begin
          // Start half a bit ahead so every later tick lands mid-bit.
          active  <= 1'b1;
          baud    <= BW'(CLKS_PER_BIT / 2);
          bit_idx <= '0;
        end
      end else if (baud == BW'(CLKS_PER_BIT - 1)) begin
        baud    <= '0;
        bit_idx <= bit_idx + 4'd1;
        if (bit_idx == 4'd0) begin
          if (rx_s) active <= 1'b0;
        end else if (bit_idx == 4'd9) begin
          active  <= 1'b0;
          rx_data <= sh;
          rx_rdy  <= 1'b1;
        end else begin
          sh <= {rx_s, sh[7:1]};
        end
      end else begin
        baud <= baud + BW'(1);
      end
    end
  end
endmodule

module remote_comm_mb #(
  parameter int CMD_BYTES      = 2,
  parameter int RESP_BYTES     = 1,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int CLKS_PER_BIT   = 868
) (
  input  logic                                              clk,
  input  logic                                              rst_n,
  input  logic                                              send_cmd,
  input  logic [8*CMD_BYTES-1:0]                            cmd,
  input  logic                                              RX,
  output logic                                              TX,
  output logic                                              busy,
  output logic                                              cmd_sent,
  output logic [8*((RESP_BYTES > 0) ? RESP_BYTES : 1)-1:0]  resp,
  output logic                                              resp_rdy,
  output logic                                              timeout
);
  localparam int CW = 8 * CMD_BYTES;
  localparam int RW = 8 * ((RESP_BYTES > 0) ? RESP_BYTES : 1);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] LOAD      = 2'd1;
  localparam logic [1:0] WAIT_TX   = 2'd2;
  localparam logic [1:0] WAIT_RESP = 2'd3;

  logic [1:0]    state;
  logic [CW-1:0] cmd_sh;
  logic [3:0]    byte_cnt;
  logic [2:0]    resp_cnt;
  logic [RW-1:0] resp_sh;
  logic [RW-1:0] resp_next;
  logic          trmt, tx_done, rx_rdy, clr_rx_rdy;
  logic [7:0]    rx_data;

  assign trmt = (state == LOAD);
  // Every received byte is consumed at once; only WAIT_RESP keeps it.
  assign clr_rx_rdy = rx_rdy;

  always_comb begin
    resp_next      = resp_sh << 8;
    resp_next[7:0] = rx_data;
  end

  remote_comm_uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk(clk), .rst_n(rst_n), .trmt(trmt), .tx_data(cmd_sh[CW-1 -: 8]),
    .TX(TX), .tx_done(tx_done)
  );

  remote_comm_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk(clk), .rst_n(rst_n), .RX(RX), .clr_rx_rdy(clr_rx_rdy),
    .rx_data(rx_data), .rx_rdy(rx_rdy)
  );

`ifdef REMOTE_COMM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt;
  logic          to_flag;
  assign timeout = to_flag;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cmd_sh   <= '0;
      byte_cnt <= '0;
      resp_cnt <= '0;
      resp_sh  <= '0;
      resp     <= '0;
      busy     <= 1'b0;
      cmd_sent <= 1'b0;
      resp_rdy <= 1'b0;
`ifdef REMOTE_COMM_TIMEOUT_EN
      to_cnt   <= '0;
      to_flag  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (send_cmd) begin
            cmd_sh   <= cmd;
            byte_cnt <= 4'(CMD_BYTES);
            cmd_sent <= 1'b0;
            resp_rdy <= 1'b0;
            busy     <= 1'b1;
            state    <= LOAD;
`ifdef REMOTE_COMM_TIMEOUT_EN
            to_flag  <= 1'b0;
`endif
          end
        end
        LOAD: begin
          cmd_sh   <= cmd_sh << 8;
          byte_cnt <= byte_cnt - 4'd1;
          state    <= WAIT_TX;
        end
        WAIT_TX: begin
          if (tx_done) begin
            if (byte_cnt != 4'd0) begin
              state <= LOAD;
            end else begin
              cmd_sent <= 1'b1;
              if (RESP_BYTES == 0) begin
                busy  <= 1'b0;
                state <= IDLE;
              end else begin
                resp_cnt <= 3'(RESP_BYTES);
                state    <= WAIT_RESP;
`ifdef REMOTE_COMM_TIMEOUT_EN
                to_cnt   <= '0;
`endif
              end
            end
          end
        end
        default: begin
          if (rx_rdy) begin
            resp_sh  <= resp_next;
            resp_cnt <= resp_cnt - 3'd1;
`ifdef REMOTE_COMM_TIMEOUT_EN
            to_cnt   <= '0;
`endif
            if (resp_cnt == 3'd1) begin
              resp     <= resp_next;
              resp_rdy <= 1'b1;
              busy     <= 1'b0;
              state    <= IDLE;
            end
          end
`ifdef REMOTE_COMM_TIMEOUT_EN
          else if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            to_flag <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
`endif
        end
      endcase
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_remote_comm_mb.sv
// Directed bench for remote_comm_mb: two instances (2/1 and 3/2 bytes) sharing a serial monitor.
`default_nettype none

module tb_remote_comm_mb;
  localparam int CPB = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        send0, send1;
  logic [15:0] cmd0;
  logic [23:0] cmd1;
  logic        rx0, rx1, tx0, tx1;
  logic        busy0, busy1, cs0, cs1, rr0, rr1, to0, to1;
  logic [7:0]  resp0;
  logic [15:0] resp1;

  logic        sel;
  logic        rx_line;
  logic        tx_mon, cs_mon, cs_prev;
  logic [7:0]  mon_b;
  logic [7:0]  tx_q[$];
  int          cs_rises = 0;
  int          tests = 0;
  int          fails = 0;
  int          qbase, csb, n;
  logic        prev_busy_v;

  always #5 clk = ~clk;

  assign rx0    = sel ? 1'b1 : rx_line;
  assign rx1    = sel ? rx_line : 1'b1;
  assign tx_mon = sel ? tx1 : tx0;
  assign cs_mon = sel ? cs1 : cs0;

  remote_comm_mb #(.CMD_BYTES(2), .RESP_BYTES(1), .TIMEOUT_CYCLES(500), .CLKS_PER_BIT(CPB)) dut0 (
    .clk(clk), .rst_n(rst_n), .send_cmd(send0), .cmd(cmd0), .RX(rx0), .TX(tx0),
    .busy(busy0), .cmd_sent(cs0), .resp(resp0), .resp_rdy(rr0), .timeout(to0)
  );

  remote_comm_mb #(.CMD_BYTES(3), .RESP_BYTES(2), .TIMEOUT_CYCLES(500), .CLKS_PER_BIT(CPB)) dut1 (
    .clk(clk), .rst_n(rst_n), .send_cmd(send1), .cmd(cmd1), .RX(rx1), .TX(tx1),
    .busy(busy1), .cmd_sent(cs1), .resp(resp1), .resp_rdy(rr1), .timeout(to1)
  );

  // Remote-side frame decoder on the selected TX line
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx_mon === 1'b0) begin
        repeat (CPB / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          mon_b[i] = tx_mon;
        end
        repeat (CPB) @(negedge clk);
        tx_q.push_back(mon_b);
      end
    end
  end

  initial begin
    cs_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (cs_mon === 1'b1 && cs_prev === 1'b0) cs_rises++;
      cs_prev = cs_mon;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] frame(input int idx);
    return (tx_q.size() > idx) ? tx_q[idx] : 8'hxx;
  endfunction

  task automatic send_rx(input logic [7:0] b);
    rx_line = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_line = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx_line = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic wait_cs(input string tag);
    int k = 0;
    while ((sel ? cs1 : cs0) !== 1'b1 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 32'(k < 3000), 32'd1);
  endtask

  task automatic wait_rr(input string tag);
    int k = 0;
    logic pb;
    pb = sel ? busy1 : busy0;
    while ((sel ? rr1 : rr0) !== 1'b1 && k < 3000) begin
      pb = sel ? busy1 : busy0;
      @(negedge clk);
      k++;
    end
    chk(tag, 32'(k < 3000), 32'd1);
    prev_busy_v = pb;
  endtask

  task automatic pulse0(input logic [15:0] c);
    cmd0 = c;
    send0 = 1'b1;
    @(negedge clk);
    send0 = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; send0 = 1'b0; send1 = 1'b0; cmd0 = '0; cmd1 = '0;
    sel = 1'b0; rx_line = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy0, 0);
    chk("rst_cmd_sent", cs0, 0);
    chk("rst_resp", resp0, 0);
    chk("rst_resp_rdy", rr0, 0);
    chk("rst_timeout", to0, 0);
    chk("rst_tx", tx0, 1);
    chk("rst_resp1", resp1, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Test 1: 2-byte command, 1-byte reply
    qbase = tx_q.size();
    pulse0(16'hA55A);
    cmd0 = 16'h0000;
    chk("t1_busy", busy0, 1);
    chk("t1_tx_idle_during_trmt", tx0, 1);
    @(negedge clk);
    chk("t1_start_bit", tx0, 0);
    wait_cs("t1_wait_cmd_sent");
    chk("t1_frame0", frame(qbase), 8'hA5);
    chk("t1_frame1", frame(qbase + 1), 8'h5A);
    chk("t1_rr_before_reply", rr0, 0);
    chk("t1_busy_before_reply", busy0, 1);
    fork
      send_rx(8'hC3);
      wait_rr("t1_wait_resp_rdy");
    join
    chk("t1_resp", resp0, 8'hC3);
    chk("t1_busy_at_rdy", busy0, 0);
    chk("t1_busy_before_rdy", prev_busy_v, 1);
    chk("t1_timeout", to0, 0);

    // Test 2: 3-byte command, 2-byte reply
    sel = 1'b1;
    repeat (4) @(negedge clk);
    qbase = tx_q.size();
    cmd1 = 24'h123456; send1 = 1'b1;
    @(negedge clk);
    send1 = 1'b0;
    wait_cs("t2_wait_cmd_sent");
    chk("t2_frame0", frame(qbase), 8'h12);
    chk("t2_frame1", frame(qbase + 1), 8'h34);
    chk("t2_frame2", frame(qbase + 2), 8'h56);
    fork
      begin send_rx(8'hBE); send_rx(8'hEF); end
      wait_rr("t2_wait_resp_rdy");
    join
    chk("t2_resp", resp1, 16'hBEEF);
    chk("t2_busy", busy1, 0);

    // Test 3: cmd change and re-pulse while busy are ignored
    sel = 1'b0;
    repeat (4) @(negedge clk);
    qbase = tx_q.size();
    csb = cs_rises;
    pulse0(16'h0F0F);
    chk("t3_rr_cleared", rr0, 0);
    repeat (10) @(negedge clk);
    pulse0(16'hFFFF);
    wait_cs("t3_wait_cmd_sent");
    fork
      send_rx(8'h5A);
      wait_rr("t3_wait_resp_rdy");
    join
    repeat (200) @(negedge clk);
    chk("t3_frame_count", tx_q.size() - qbase, 2);
    chk("t3_frame0", frame(qbase), 8'h0F);
    chk("t3_frame1", frame(qbase + 1), 8'h0F);
    chk("t3_cs_rises", cs_rises - csb, 1);
    chk("t3_idle_after", busy0, 0);
    chk("t3_resp", resp0, 8'h5A);

    // Test 4: unsolicited byte in IDLE is discarded
    send_rx(8'h77);
    repeat (10) @(negedge clk);
    chk("t4_resp_untouched", resp0, 8'h5A);
    chk("t4_rr_held", rr0, 1);
    pulse0(16'h1234);
    wait_cs("t4_wait_cmd_sent");
    fork
      send_rx(8'h11);
      wait_rr("t4_wait_resp_rdy");
    join
    chk("t4_resp", resp0, 8'h11);

    // Test 5: reset during the second command byte
    repeat (4) @(negedge clk);
    pulse0(16'hBEEF);
    repeat (120) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_busy", busy0, 0);
    chk("t5_rst_cmd_sent", cs0, 0);
    chk("t5_rst_resp_rdy", rr0, 0);
    chk("t5_rst_resp", resp0, 0);
    chk("t5_rst_tx", tx0, 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (120) @(negedge clk);
    qbase = tx_q.size();
    pulse0(16'h3CC3);
    wait_cs("t5_wait_cmd_sent");
    chk("t5_frame_count", tx_q.size() - qbase, 2);
    chk("t5_frame0", frame(qbase), 8'h3C);
    chk("t5_frame1", frame(qbase + 1), 8'hC3);
    fork
      send_rx(8'h99);
      wait_rr("t5_wait_resp_rdy");
    join
    chk("t5_resp", resp0, 8'h99);

`ifdef REMOTE_COMM_TIMEOUT_EN
    // Test 6: no reply -> timeout 500 clocks after entering the response phase
    repeat (4) @(negedge clk);
    pulse0(16'h4242);
    wait_cs("t6_wait_cmd_sent");
    n = 0;
    while (to0 !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("t6_timeout_latency", n, 500);
    chk("t6_resp_rdy", rr0, 0);
    chk("t6_resp_held", resp0, 8'h99);
    chk("t6_busy", busy0, 0);
`else
    chk("t6_timeout_tied", to0, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

`default_nettype wire
